// File: rtl/seq_divider_32_pkg.sv
// Shared definitions for the multi-cycle restoring divider: FSM state encoding
// and default sizing.
package seq_divider_32_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_CNT_W = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } div_state_t;

endpackage

// File: rtl/seq_divider_32_if.sv
// Request/result bundle between the MIPS control/datapath and the divider.
interface seq_divider_32_if #(
    parameter int WIDTH = seq_divider_32_pkg::DIV_WIDTH
);
    logic             start;
    logic             is_signed;
    logic             flush;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, is_signed, flush, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, is_signed, flush, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_divider_32_div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract
// the divisor magnitude and keep or restore the partial remainder.
module seq_divider_32_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic             i_bit,
    input  logic [WIDTH-1:0] i_dvs,
    output logic [WIDTH-1:0] o_rem,
    output logic             o_q
);
    logic [WIDTH:0]   w_shift;
    logic [WIDTH+1:0] w_sum;
    logic             w_unused_msb;

    assign w_shift = {i_rem, i_bit};

    // Subtract as add-of-complement; the carry out is the no-borrow flag.
    assign w_sum = {1'b0, w_shift} + {1'b0, ~{1'b0, i_dvs}} + (WIDTH+2)'(1);

    assign o_q          = w_sum[WIDTH+1];
    assign o_rem        = o_q ? w_sum[WIDTH-1:0] : w_shift[WIDTH-1:0];
    assign w_unused_msb = w_sum[WIDTH];
endmodule

// File: rtl/seq_divider_32.sv
// Multi-cycle restoring divider for DIV/DIVU: one quotient bit per clock,
// sign correction in FIX, fixed latency regardless of operands.
module seq_divider_32
    import seq_divider_32_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = DIV_CNT_W
) (
    input logic              clk,
    input logic              rst_n,
    seq_divider_32_if.slave  bus
);
    div_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic             r_done;
    logic             r_dbz;
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;

    logic             r_sign_a;
    logic             r_sign_b;
    logic             r_b_zero;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_dvs;

    logic             w_accept;
    logic             w_iterate;
    logic [WIDTH-1:0] w_step_rem;
    logic             w_step_q;
    logic [WIDTH-1:0] w_quo_fix;
    logic [WIDTH-1:0] w_rem_fix;

    function automatic logic [WIDTH-1:0] f_neg(input logic [WIDTH-1:0] v);
        return ~v + WIDTH'(1);
    endfunction

    // -2^(WIDTH-1) maps onto itself, which reads correctly as an unsigned magnitude.
    function automatic logic [WIDTH-1:0] f_mag(input logic [WIDTH-1:0] v, input logic sgn);
        return (sgn && v[WIDTH-1]) ? f_neg(v) : v;
    endfunction

    assign w_accept  = (r_state == ST_IDLE) && bus.start && !bus.flush;
    assign w_iterate = (r_state == ST_CALC) && (r_cnt != '0);

    seq_divider_32_div_step #(.WIDTH(WIDTH)) u_step (
        .i_rem (r_rem),
        .i_bit (r_quo[WIDTH-1]),
        .i_dvs (r_dvs),
        .o_rem (w_step_rem),
        .o_q   (w_step_q)
    );

    // With a zero divisor every trial succeeds, so the raw remainder is |a|;
    // re-applying sign(a) restores the original dividend.
    assign w_quo_fix = r_b_zero            ? '1
                     : (r_sign_a ^ r_sign_b) ? f_neg(r_quo) : r_quo;
    assign w_rem_fix = r_sign_a ? f_neg(r_rem) : r_rem;

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_sign_a <= bus.is_signed & bus.dividend[WIDTH-1];
            r_sign_b <= bus.is_signed & bus.divisor[WIDTH-1];
            r_b_zero <= (bus.divisor == '0);
            r_quo    <= f_mag(bus.dividend, bus.is_signed);
            r_dvs    <= f_mag(bus.divisor, bus.is_signed);
            r_rem    <= '0;
        end else if (w_iterate) begin
            r_rem    <= w_step_rem;
            r_quo    <= {r_quo[WIDTH-2:0], w_step_q};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_dbz       <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
        end else if (bus.flush) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_state <= ST_CALC;
                        r_cnt   <= CNT_W'(WIDTH);
                        r_busy  <= 1'b1;
                    end
                end
                ST_CALC: begin
                    if (r_cnt == '0) begin
                        r_state <= ST_FIX;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                ST_FIX: begin
                    r_state     <= ST_DONE;
                    r_done      <= 1'b1;
                    r_quotient  <= w_quo_fix;
                    r_remainder <= w_rem_fix;
                    r_dbz       <= r_b_zero;
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.quotient    = r_quotient;
    assign bus.remainder   = r_remainder;
    assign bus.div_by_zero = r_dbz;
endmodule

// File: tb/tb_seq_divider_32.sv
// Directed bench for seq_divider_32: hand-computed DIV/DIVU vectors, latency,
// ignored start, flush and asynchronous reset.
module tb_seq_divider_32;
    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_miss;

    seq_divider_32_if #(.WIDTH(32)) bus ();

    seq_divider_32 #(.WIDTH(32), .CNT_W(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic sgn,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eq, input logic [31:0] er,
                          input logic edbz, input int poke_at);
        int k;
        int busy_low;
        @(negedge clk);
        bus.start     = 1'b1;
        bus.is_signed = sgn;
        bus.dividend  = a;
        bus.divisor   = b;
        @(negedge clk);
        bus.start = 1'b0;
        chk({tag, "_busy_after_accept"}, {31'b0, bus.busy}, 32'd1);
        k        = 0;
        busy_low = 0;
        while (bus.done !== 1'b1 && k < 60) begin
            if (k == poke_at) begin
                bus.start     = 1'b1;
                bus.is_signed = 1'b0;
                bus.dividend  = 32'd50;
                bus.divisor   = 32'd5;
            end
            @(negedge clk);
            k++;
            bus.start = 1'b0;
            if (bus.busy !== 1'b1) busy_low++;
        end
        chk({tag, "_latency"}, k, 32'd34);
        chk({tag, "_busy_gaps"}, busy_low, 32'd0);
        chk({tag, "_quotient"}, bus.quotient, eq);
        chk({tag, "_remainder"}, bus.remainder, er);
        chk({tag, "_dbz"}, {31'b0, bus.div_by_zero}, {31'b0, edbz});
        @(negedge clk);
        chk({tag, "_done_one_cycle"}, {31'b0, bus.done}, 32'd0);
        chk({tag, "_busy_cleared"}, {31'b0, bus.busy}, 32'd0);
    endtask

    task automatic count_done(input string tag, input int cycles);
        int seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) seen++;
        end
        chk(tag, seen, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec         = 0;
        n_miss        = 0;
        rst_n         = 1'b1;
        bus.start     = 1'b0;
        bus.is_signed = 1'b0;
        bus.flush     = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        #3 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'b0, bus.busy}, 32'd0);
        chk("rst_done", {31'b0, bus.done}, 32'd0);
        chk("rst_quotient", bus.quotient, 32'd0);
        chk("rst_remainder", bus.remainder, 32'd0);
        chk("rst_dbz", {31'b0, bus.div_by_zero}, 32'd0);
        rst_n = 1'b1;

        // start pulsed mid-operation with other operands must be ignored
        run_op("divu_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 10);
        count_done("no_extra_done", 40);

        run_op("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, -1);
        run_op("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0, -1);
        run_op("div_m100_m7", 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 32'hFFFF_FFFE, 1'b0, -1);
        run_op("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, -1);
        run_op("divu_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, -1);
        run_op("divu_m7_2", 1'b0, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 32'd1, 1'b0, -1);
        run_op("divu_min_max", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, -1);
        run_op("div_1234_0", 1'b1, 32'd1234, 32'd0, 32'hFFFF_FFFF, 32'd1234, 1'b1, -1);
        run_op("divu_1234_0", 1'b0, 32'd1234, 32'd0, 32'hFFFF_FFFF, 32'd1234, 1'b1, -1);
        run_op("div_m7_0", 1'b1, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b1, -1);

        // flush at cycle 15, then flush together with start in IDLE
        @(negedge clk);
        bus.start     = 1'b1;
        bus.is_signed = 1'b0;
        bus.dividend  = 32'd50;
        bus.divisor   = 32'd5;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (14) @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        chk("flush_busy", {31'b0, bus.busy}, 32'd0);
        chk("flush_done", {31'b0, bus.done}, 32'd0);
        bus.flush = 1'b1;
        bus.start = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        bus.start = 1'b0;
        chk("flush_start_busy", {31'b0, bus.busy}, 32'd0);
        count_done("flush_no_done", 40);
        chk("flush_q_held", bus.quotient, 32'hFFFF_FFFF);
        chk("flush_r_held", bus.remainder, 32'hFFFF_FFF9);
        chk("flush_dbz_held", {31'b0, bus.div_by_zero}, 32'd1);

        // asynchronous reset in the middle of an operation
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 32'd1000;
        bus.divisor  = 32'd3;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (19) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", {31'b0, bus.busy}, 32'd0);
        chk("arst_done", {31'b0, bus.done}, 32'd0);
        chk("arst_quotient", bus.quotient, 32'd0);
        chk("arst_remainder", bus.remainder, 32'd0);
        chk("arst_dbz", {31'b0, bus.div_by_zero}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("divu_1000_3", 1'b0, 32'd1000, 32'd3, 32'd333, 32'd1, 1'b0, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/seq_divider_32.md
Name: seq_divider_32

Overview:
Multi-cycle restoring divider for the MIPS datapath. It executes DIV and DIVU, producing the quotient for LO and the remainder for HI. It is the inverse operation of the adder/ALU slice chain, using iterative shift-and-subtract, one quotient bit per clock. It sits beside the single-cycle ALU; control stalls the PC while busy is high.

Parameters:
WIDTH, 32, operand/result width in bits (must be >= 2)
CNT_W, 6, iteration counter width (must hold WIDTH)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
is_signed  input  1  1 = DIV (two's complement), 0 = DIVU; captured with start
flush  input  1  synchronous abort; returns to IDLE next edge
dividend  input  WIDTH  numerator; captured with start
divisor  input  WIDTH  denominator; captured with start
busy  output  1  high from the cycle after start acceptance until done
done  output  1  single-cycle pulse; results valid
quotient  output  WIDTH  to LO
remainder  output  WIDTH  to HI
div_by_zero  output  1  registered flag, valid with done, held until next acceptance

Behaviour:
- Interface decided: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset drives state to IDLE. busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, counter=0.
- States:
  - IDLE: start=1 latches the operands, is_signed and the signs. It stores the magnitudes |a| and |b| (for signed operands) or the raw values, clears the partial remainder, sets counter=WIDTH, and goes to CALC.
  - CALC: each cycle, shift {rem,quo} left by 1 and trial-subtract |b| from the upper part. If there is no borrow, keep the difference and set quo[0]=1; otherwise restore and set quo[0]=0. Decrement the counter. Leave CALC after WIDTH iterations.
  - FIX: apply the sign correction.
    - Quotient is negated if sign(a) XOR sign(b).
    - Remainder is negated if sign(a).
    - Sign correction applies only when is_signed=1.
  - DONE: done=1 for exactly one cycle. Return to IDLE.
- Latency: start sampled at edge N. done is high during the cycle after edge N+WIDTH+2 (34 cycles for WIDTH=32). Latency is fixed and independent of data.
- busy=1 in CALC, FIX and DONE. busy=0 in IDLE.
- start while busy is ignored; no queueing.
- start is accepted in the same edge that DONE returns to IDLE only if it is present in IDLE. Back-to-back operations therefore have a 1-cycle gap.
- Divide by zero:
  - Iterations still run; fixed latency is kept.
  - Outputs are quotient = all ones, remainder = original dividend (unnegated), div_by_zero=1.
  - Sign correction is suppressed.
- Signed overflow: -2^(WIDTH-1) / -1 gives quotient = 0x80000000 and remainder = 0, with no flag.
- quotient, remainder and div_by_zero update only on the FIX->DONE edge. They hold their values through IDLE and the next CALC until the next FIX.
- flush has priority over everything except rst_n.
  - In any state, the next edge goes to IDLE with busy=0 and done=0.
  - Result registers keep their previous values.
  - flush and start together: flush wins, start is dropped.
- Reset mid-operation aborts immediately and all outputs take their reset values.
- Magnitude of -2^(WIDTH-1) is 2^(WIDTH-1) as unsigned WIDTH bits, with no extension. The trial subtract is WIDTH+1 bits wide for borrow detection.

Decomposition:
- Shared package (div_pkg): state encodings IDLE/CALC/FIX/DONE as 2-bit localparams, and the WIDTH default.
- One sub-module, div_step: combinational, WIDTH-parametric.
  - Inputs: partial remainder, next dividend bit, divisor.
  - Outputs: new remainder and quotient bit.
  - Built from the team's existing adder/inverter primitives.
- The FSM, counter and sign fix stay in seq_divider_32.

Test Plan:
- DIVU 100/7: start, is_signed=0 -> done at cycle 34, quotient=14, remainder=2, div_by_zero=0, busy high cycles 1-33.
- DIV -7/2 (0xFFFFFFF9/2) -> quotient=0xFFFFFFFD (-3), remainder=0xFFFFFFFF (-1). DIV 7/-2 -> quotient=-3, remainder=1.
- DIV 0x80000000/0xFFFFFFFF -> quotient=0x80000000, remainder=0. DIVU 0xFFFFFFFF/1 -> quotient=0xFFFFFFFF, remainder=0.
- Divide by zero 1234/0 (signed and unsigned) -> quotient=0xFFFFFFFF, remainder=1234, div_by_zero=1, still 34-cycle latency.
- start pulsed at cycle 10 of an operation with new operands -> ignored; first result unchanged, no extra done.
- flush at cycle 15 -> busy=0 next cycle, no done, prior results held. rst_n low at cycle 20 of a new op -> all outputs 0 immediately (asynchronous).
